// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared state encoding and frame layout constants for the SPI register bridge
package spi_reg_pkg;
    typedef enum logic [2:0] {IDLE, CMD, RD_ISSUE, RD_WAIT, DATA, COMMIT, DONE} state_t;
    localparam int CMD_RW_BIT = 7;
    localparam int CMD_RSVD_BIT = 6;
    localparam int FRAME_BITS = 16;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchronizes the SPI pins into the system clock and detects sclk/cs_n edges
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_s
);
    // Index SYNC_STAGES is the previous synchronized sample used for edge detection.
    logic [SYNC_STAGES:0] sclk_q, cs_q;
    logic [SYNC_STAGES-1:0] mosi_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_q <= '0;
            cs_q <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], sclk};
            cs_q <= {cs_q[SYNC_STAGES-1:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];
    assign cs_rise = cs_q[SYNC_STAGES-1] & ~cs_q[SYNC_STAGES];
    assign cs_fall = ~cs_q[SYNC_STAGES-1] & cs_q[SYNC_STAGES];
    assign mosi_s = mosi_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 target turning 16-bit host frames into register-file reads and writes
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic [ADDR_W-1:0] address,
    output logic              write_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              read_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              frame_error,
    output logic              busy
);
    localparam logic [3:0] CMD_LAST = 4'(FRAME_BITS - DATA_W - 1);
    localparam logic [3:0] DATA_LAST = 4'(FRAME_BITS - 1);

    state_t state;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
    logic [3:0] cnt;
    logic [DATA_W-1:0] sr, miso_sr, shifted;
    logic [7:0] cmd;
    logic rw, overrun;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clock(clock),
        .reset(reset),
        .sclk(spi_sclk),
        .cs_n(spi_cs_n),
        .mosi(spi_mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_fall(cs_fall),
        .cs_rise(cs_rise),
        .mosi_s(mosi_s)
    );

    assign shifted = {sr[DATA_W-2:0], mosi_s};
    assign cmd = shifted[7:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            sr <= '0;
            miso_sr <= '0;
            rw <= 1'b0;
            overrun <= 1'b0;
            address <= '0;
            wr_data <= '0;
            write_en <= 1'b0;
            read_en <= 1'b0;
            frame_error <= 1'b0;
            busy <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            write_en <= 1'b0;
            read_en <= 1'b0;
            frame_error <= 1'b0;
            // A CS rise outranks any sclk edge seen in the same cycle.
            if (cs_rise && state != IDLE) begin
                state <= IDLE;
                busy <= 1'b0;
                spi_miso_oe <= 1'b0;
                spi_miso <= 1'b0;
                frame_error <= state != DONE;
            end else begin
                case (state)
                    IDLE: if (cs_fall) begin
                        state <= CMD;
                        cnt <= '0;
                        miso_sr <= '0;
                        overrun <= 1'b0;
                        busy <= 1'b1;
                        spi_miso_oe <= 1'b1;
                        spi_miso <= 1'b0;
                    end
                    CMD: if (sclk_rise) begin
                        sr <= shifted;
                        cnt <= cnt + 4'd1;
                        if (cnt == CMD_LAST) begin
                            address <= cmd[ADDR_W-1:0];
                            // A reserved-bit command becomes a read that returns zeros without touching the register file.
                            rw <= cmd[CMD_RW_BIT] | cmd[CMD_RSVD_BIT];
                            frame_error <= cmd[CMD_RSVD_BIT];
                            state <= (cmd[CMD_RW_BIT] && !cmd[CMD_RSVD_BIT]) ? RD_ISSUE : DATA;
                        end
                    end
                    RD_ISSUE: begin
                        read_en <= 1'b1;
                        state <= RD_WAIT;
                    end
                    RD_WAIT: if (!read_en) begin
                        miso_sr <= rd_data;
                        state <= DATA;
                    end
                    DATA: if (sclk_rise) begin
                        sr <= shifted;
                        cnt <= cnt + 4'd1;
                        if (cnt == DATA_LAST) begin
                            if (!rw) wr_data <= shifted;
                            state <= rw ? DONE : COMMIT;
                        end
                    end else if (sclk_fall) begin
                        spi_miso <= miso_sr[DATA_W-1];
                        miso_sr <= {miso_sr[DATA_W-2:0], 1'b0};
                    end
                    COMMIT: begin
                        write_en <= 1'b1;
                        state <= DONE;
                    end
                    DONE: if (sclk_rise && !overrun) begin
                        frame_error <= 1'b1;
                        overrun <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
